// File: rtl/transmitter_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and default timing.
package transmitter_pkg;

    // Frame sequencing states of the serial transmitter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // 50 MHz system clock at 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    // Bytes buffered ahead of the serializer.
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/transmitter_fifo.sv
// tx_fifo: small synchronous circular buffer with show-ahead output.
// The head entry is visible on dout whenever the buffer is non-empty, so the
// serializer can load it on the same edge it pops.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Overflow and underflow requests are dropped, never corrupt state.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign dout  = mem[rd_ptr_reg];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/transmitter.sv
// transmitter: buffered 8N1 UART transmitter. Bytes are queued in tx_fifo and
// serialized LSB first; back-to-back frames leave no idle gap on the line.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_t   state_reg;
    tx_state_t   state_next;
    logic [CW-1:0] cnt_reg;
    logic [2:0]  idx_reg;
    logic [7:0]  shift_reg;
    logic        tx_reg;
    logic        bit_end;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid),
        .pop   (pop),
        .din   (data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Readiness depends only on buffer occupancy, never on valid.
    assign ready   = !fifo_full;
    assign tx      = tx_reg;
    assign bit_end = (cnt_reg == CNT_MAX);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: one bit period per START/STOP, eight for DATA.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!fifo_empty)                  state_next = ST_START;
            ST_START: if (bit_end)                      state_next = ST_DATA;
            ST_DATA:  if (bit_end && idx_reg == 3'd7)   state_next = ST_STOP;
            ST_STOP:  if (bit_end)                      state_next = fifo_empty ? ST_IDLE : ST_START;
            default:                                    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: pop the buffer when a new frame begins, flag frame completion.
    always_comb begin
        pop  = 1'b0;
        done = 1'b0;
        busy = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE: pop = !fifo_empty;
            ST_STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    pop  = !fifo_empty;
                end
            end
            default: ;
        endcase
    end

    // Bit-period counter: held at zero while idle, wraps at every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_IDLE || bit_end) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Shift register and line driver; tx changes only on bit boundaries or a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            idx_reg   <= '0;
            tx_reg    <= 1'b1;
        end else if (pop) begin
            shift_reg <= fifo_dout;
            idx_reg   <= '0;
            tx_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: tx_reg <= 1'b1;
                ST_START: begin
                    if (bit_end) begin
                        tx_reg  <= shift_reg[0];
                        idx_reg <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (idx_reg == 3'd7) begin
                            tx_reg <= 1'b1;
                        end else begin
                            tx_reg    <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                            idx_reg   <= idx_reg + 3'd1;
                        end
                    end
                end
                ST_STOP: if (bit_end) tx_reg <= 1'b1;
                default: tx_reg <= 1'b1;
            endcase
        end
    end

endmodule
